vga_frame_timing: RTL

- Generates 640x480@60 VGA raster timing on the pixel clock clkDiv.
- Drives the Game of Life core and its row-transfer logic with row, column, displayActive, drawRequest and noise, and drives the VGA connector sync pins.
- Also conditions the user "draw" button and supplies the pseudo-random seed bit used for initial board fill.
- Sits directly upstream of the Game of Life core; all its outputs are consumed on clkDiv.

---
 rtl/vga_frame_timing.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_frame_timing.sv
`default_nettype none
// ============================================================================
// Module  : vga_frame_timing
// Purpose : VGA raster timing, debounced draw request and LFSR noise on clkDiv
// Rev     : 1.0  initial release
// ============================================================================
module vga_frame_timing #(
  parameter int          H_ACTIVE        = 640,
  parameter int          H_FP            = 16,
  parameter int          H_SYNC          = 96,
  parameter int          H_BP            = 48,
  parameter int          V_ACTIVE        = 480,
  parameter int          V_FP            = 10,
  parameter int          V_SYNC          = 2,
  parameter int          V_BP            = 33,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clkDiv,
  input  logic       rst,
  input  logic       btnRaw,
  output logic       hsync,
  output logic       vsync,
  output logic       displayActive,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic       frameStart,
  output logic       drawRequest,
  output logic       noise
);

  localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int         c_db_w     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  logic [9:0]        col_q, col_d;
  logic [9:0]        line_q, line_d;
  logic [8:0]        row_q, row_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic              fs_q, fs_d;
  logic              draw_q, draw_d;
  logic              noise_q, noise_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              sync1_q, sync2_q;
  logic              acc_q, acc_d;
  logic [c_db_w-1:0] dbcnt_q, dbcnt_d;

  // Outputs are decoded from the next pixel position so every output register
  // describes the same pixel as column in the same cycle.
  always_comb begin
    col_d  = col_q + 10'd1;
    line_d = line_q;
    if (col_q == c_h_last) begin
      col_d  = '0;
      line_d = (line_q == c_v_last) ? '0 : line_q + 10'd1;
    end
    row_d   = (line_d < c_v_active) ? line_d[8:0] : 9'(line_d - c_v_active);
    de_d    = (col_d < c_h_active) && (line_d < c_v_active);
    hsync_d = !((col_d >= c_hs_start) && (col_d < c_hs_end));
    vsync_d = !((line_d >= c_vs_start) && (line_d < c_vs_end));
    fs_d    = (col_d == '0) && (line_d == '0);
    draw_d  = fs_d ? acc_q : draw_q;
  end

  always_comb begin
    acc_d   = acc_q;
    dbcnt_d = dbcnt_q;
    if (sync2_q == acc_q) begin
      dbcnt_d = '0;
    end else if (dbcnt_q == c_db_last) begin
      acc_d   = sync2_q;
      dbcnt_d = '0;
    end else begin
      dbcnt_d = dbcnt_q + 1'b1;
    end
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    noise_d = lfsr_d[0];
  end

  always_ff @(posedge clkDiv or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      line_q  <= '0;
      row_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b1;
      fs_q    <= 1'b0;
      draw_q  <= 1'b0;
      noise_q <= LFSR_SEED[0];
      lfsr_q  <= LFSR_SEED;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      acc_q   <= 1'b0;
      dbcnt_q <= '0;
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      draw_q  <= draw_d;
      noise_q <= noise_d;
      lfsr_q  <= lfsr_d;
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      dbcnt_q <= dbcnt_d;
    end
  end

  assign column        = col_q;
  assign row           = row_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign displayActive = de_q;
  assign frameStart    = fs_q;
  assign drawRequest   = draw_q;
  assign noise         = noise_q;

endmodule
`default_nettype wire
